pcie_tlp_tx_arb: RTL and testbench
==================================

PCIE_TLP_TX_ARB -- requirements
Module: pcie_tlp_tx_arb

Interface
REQ-001 SHALL have parameter CPL_PRIO, default 1, meaning requester 1 (completion source) wins when both requesters are valid and the grant is idle.
REQ-002 SHALL have parameter MAX_BEATS, default 258, meaning the beat limit per packet before the watchdog forces release.
REQ-003 pcie_clk  input  1  single clock; all logic rising-edge.
REQ-004 pcie_rstn  input  1  synchronous, active-low reset.
REQ-005 rq0_tdata/tkeep/tlast/tuser/tvalid  input  64/8/1/4/1  requester 0 (memory request TLPs) AXI-S TX stream.
REQ-006 rq0_tready  output  1  requester 0 backpressure.
REQ-007 rq1_tdata/tkeep/tlast/tuser/tvalid  input  64/8/1/4/1  requester 1 (completion TLPs) AXI-S TX stream.
REQ-008 rq1_tready  output  1  requester 1 backpressure.
REQ-009 tx_tdata/tkeep/tlast/tuser/tvalid  output  64/8/1/4/1  merged stream to PCIe core TX.
REQ-010 tx_tready  input  1  core backpressure.
REQ-011 grant  output  2  one-hot active grant; 2'b00 when idle.
REQ-012 pkt_cnt0, pkt_cnt1  output  32  packets forwarded per requester.
REQ-013 wdog_err  output  1  sticky; set when a packet exceeds MAX_BEATS.

Function
REQ-014 SHALL arbitrate per packet; FSM states IDLE, GNT0, GNT1.
REQ-015 IDLE: single rqN_tvalid -> GNTN next cycle; both valid -> GNT1 if CPL_PRIO=1, else the requester not served last (round-robin, last-served initialised to 1).
REQ-016 GNTN: hold grant until a beat with rqN_tlast=1 is accepted into the output stage, then -> IDLE; no beats of the other requester are interleaved.
REQ-017 rqN_tvalid low mid-packet SHALL keep the grant (no timeout on bubbles).
REQ-018 Only the granted requester sees rqN_tready=1, and only when the output stage can accept; ungranted tready=0.
REQ-019 Output stage SHALL be a 2-entry skid buffer: tx_* registered, latency exactly 1 cycle from input handshake to tx_tvalid; full throughput (1 beat/cycle) with tx_tready held high.
REQ-020 tx_tdata/tkeep/tlast/tuser SHALL stay stable while tx_tvalid=1 and tx_tready=0.
REQ-021 Single-beat packet (tlast on first beat) SHALL be legal; FSM returns to IDLE and may re-grant on the following cycle (IDLE costs one cycle per packet).
REQ-022 pkt_cntN SHALL increment by 1 when a tlast beat of requester N is accepted; wraps 0xFFFF_FFFF -> 0.
REQ-023 Beat counter (9 bits) SHALL reset at packet start; at MAX_BEATS accepted beats without tlast, arbiter SHALL set wdog_err, force tx_tlast=1 on that beat, and return to IDLE.
REQ-024 Simultaneous tlast acceptance and new request in same cycle SHALL not grant until IDLE is reached.

Reset
REQ-025 pcie_rstn=0 at a clock edge SHALL put FSM in IDLE, clear skid buffer, tx_tvalid=0, rq0/1_tready=0, grant=0, pkt_cnt0/1=0, wdog_err=0, last-served=1.
REQ-026 Reset mid-packet SHALL discard the in-flight packet; no partial beats emitted after reset release.

Structure
REQ-027 PCIE_TDATA64, PCIE_TKEEP64, PCIE_TUSER64_TX, PCIE_TLAST64 and the new ARB_STATE enum (IDLE, GNT0, GNT1) SHALL live in the shared TLP package.
REQ-028 Skid buffer SHALL be sub-module pcie_axis_skid64, reused for any 64-bit TX stage.

Verification
REQ-029 rq0 sends 2-beat MRd (3DW, raw 0x0000_000F_0000_0001 / addr 0x1000), tx_tready=1 -> identical beats on tx 1 cycle later, grant=01, pkt_cnt0=1.
REQ-030 rq0 and rq1 valid same cycle, CPL_PRIO=1 -> rq1's 3-beat CplD fully emitted before rq0's first beat; then rq0 granted.
REQ-031 CPL_PRIO=0, both requesters continuously valid with 1-beat packets -> grant alternates 10,01,10,...; tx shows no interleave.
REQ-032 tx_tready toggled 1,0,0,1 during 4-beat packet -> no beat lost/duplicated, tdata stable during stalls.
REQ-033 rq0 streams 300 beats without tlast, MAX_BEATS=258 -> beat 258 has tx_tlast=1, wdog_err=1 sticky, FSM IDLE.
REQ-034 pcie_rstn=0 during beat 2 of 4 -> tx_tvalid=0 next cycle, counters 0; next packet after release emitted intact.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// Shared TLP stream definitions for the 64-bit PCIe TX path.
package pcie_tlp_pkg;
  localparam int PCIE_TDATA64    = 64;
  localparam int PCIE_TKEEP64    = 8;
  localparam int PCIE_TUSER64_TX = 4;
  localparam int PCIE_TLAST64    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [PCIE_TDATA64-1:0]    tdata;
    logic [PCIE_TKEEP64-1:0]    tkeep;
    logic [PCIE_TLAST64-1:0]    tlast;
    logic [PCIE_TUSER64_TX-1:0] tuser;
  } tlp_beat_t;
endpackage

// File: rtl/pcie_axis_skid64.sv
// Two-entry skid buffer for a 64-bit AXI-S TX stage; registered output, 1-cycle latency.
module pcie_axis_skid64
  import pcie_tlp_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  tlp_beat_t in_beat,
  input  logic      in_valid,
  output logic      in_ready,
  output tlp_beat_t out_beat,
  output logic      out_valid,
  input  logic      out_ready
);
  tlp_beat_t skid;
  logic      skid_valid;

  // Ready depends only on registered state, so upstream sees no comb path from out_ready.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_beat   <= '0;
      skid       <= '0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_beat   <= skid;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_beat <= in_beat;
      end
    end else if (in_valid && !skid_valid) begin
      skid       <= in_beat;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/pcie_tlp_tx_arb.sv
// Packet-level arbiter merging memory-request and completion TLP streams onto one TX port.
module pcie_tlp_tx_arb
  import pcie_tlp_pkg::*;
#(
  parameter int CPL_PRIO  = 1,
  parameter int MAX_BEATS = 258
) (
  input  logic                       pcie_clk,
  input  logic                       pcie_rstn,
  input  logic [PCIE_TDATA64-1:0]    rq0_tdata,
  input  logic [PCIE_TKEEP64-1:0]    rq0_tkeep,
  input  logic                       rq0_tlast,
  input  logic [PCIE_TUSER64_TX-1:0] rq0_tuser,
  input  logic                       rq0_tvalid,
  output logic                       rq0_tready,
  input  logic [PCIE_TDATA64-1:0]    rq1_tdata,
  input  logic [PCIE_TKEEP64-1:0]    rq1_tkeep,
  input  logic                       rq1_tlast,
  input  logic [PCIE_TUSER64_TX-1:0] rq1_tuser,
  input  logic                       rq1_tvalid,
  output logic                       rq1_tready,
  output logic [PCIE_TDATA64-1:0]    tx_tdata,
  output logic [PCIE_TKEEP64-1:0]    tx_tkeep,
  output logic                       tx_tlast,
  output logic [PCIE_TUSER64_TX-1:0] tx_tuser,
  output logic                       tx_tvalid,
  input  logic                       tx_tready,
  output logic [1:0]                 grant,
  output logic [31:0]                pkt_cnt0,
  output logic [31:0]                pkt_cnt1,
  output logic                       wdog_err
);
  arb_state_e state;
  logic       last_served;
  logic [8:0] beat_cnt;
  tlp_beat_t  sel, in_beat, out_beat;
  logic       sel_valid, in_ready, acc, wdog_hit, eop;

  always_comb begin
    sel        = (state == GNT1) ? {rq1_tdata, rq1_tkeep, rq1_tlast, rq1_tuser}
                                 : {rq0_tdata, rq0_tkeep, rq0_tlast, rq0_tuser};
    sel_valid  = ((state == GNT0) && rq0_tvalid) || ((state == GNT1) && rq1_tvalid);
    rq0_tready = (state == GNT0) && in_ready;
    rq1_tready = (state == GNT1) && in_ready;
    acc        = sel_valid && in_ready;
    // Runaway packet: cut it at MAX_BEATS by forcing tlast on the limit beat.
    wdog_hit   = acc && !sel.tlast[0] && (beat_cnt == 9'(MAX_BEATS - 1));
    eop        = acc && (sel.tlast[0] || wdog_hit);
    in_beat    = sel;
    in_beat.tlast[0] = sel.tlast[0] || wdog_hit;
  end

  always_ff @(posedge pcie_clk) begin
    if (!pcie_rstn) begin
      state       <= IDLE;
      grant       <= 2'b00;
      last_served <= 1'b1;
      beat_cnt    <= '0;
      pkt_cnt0    <= '0;
      pkt_cnt1    <= '0;
      wdog_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          // Completions win outright when prioritised, otherwise round-robin on contention.
          if (rq1_tvalid && (!rq0_tvalid || (CPL_PRIO != 0) || !last_served)) begin
            state       <= GNT1;
            grant       <= 2'b10;
            last_served <= 1'b1;
          end else if (rq0_tvalid) begin
            state       <= GNT0;
            grant       <= 2'b01;
            last_served <= 1'b0;
          end
        end
        default: begin
          if (acc) beat_cnt <= beat_cnt + 9'd1;
          if (wdog_hit) wdog_err <= 1'b1;
          if (eop) begin
            state <= IDLE;
            grant <= 2'b00;
            if (state == GNT0) pkt_cnt0 <= pkt_cnt0 + 32'd1;
            else               pkt_cnt1 <= pkt_cnt1 + 32'd1;
          end
        end
      endcase
    end
  end

  pcie_axis_skid64 u_skid (
    .clk      (pcie_clk),
    .rstn     (pcie_rstn),
    .in_beat  (in_beat),
    .in_valid (sel_valid),
    .in_ready (in_ready),
    .out_beat (out_beat),
    .out_valid(tx_tvalid),
    .out_ready(tx_tready)
  );

  assign {tx_tdata, tx_tkeep, tx_tlast, tx_tuser} = out_beat;
endmodule

// File: tb/tb_pcie_tlp_tx_arb.sv
// Scoreboard bench for pcie_tlp_tx_arb: priority, round-robin, stalls, watchdog and reset.
module tb_pcie_tlp_tx_arb;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [3:0]  u;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic [63:0] rq0_tdata, rq1_tdata, tx_tdata;
  logic [7:0]  rq0_tkeep, rq1_tkeep, tx_tkeep;
  logic        rq0_tlast, rq1_tlast, tx_tlast;
  logic [3:0]  rq0_tuser, rq1_tuser, tx_tuser;
  logic        rq0_tvalid, rq1_tvalid, tx_tvalid;
  logic        rq0_tready, rq1_tready, tx_tready;
  logic [1:0]  grant;
  logic [31:0] pkt_cnt0, pkt_cnt1;
  logic        wdog_err;

  // Second instance for round-robin mode, driven directly.
  logic        r0_tvalid, r1_tvalid, r0_tready, r1_tready;
  logic [63:0] r_tx_tdata;
  logic [7:0]  r_tx_tkeep;
  logic        r_tx_tlast, r_tx_tvalid, r_wdog;
  logic [3:0]  r_tx_tuser;
  logic [1:0]  r_grant;
  logic [31:0] r_cnt0, r_cnt1;

  pcie_tlp_tx_arb #(.CPL_PRIO(1), .MAX_BEATS(258)) u_dut (
    .pcie_clk(clk), .pcie_rstn(rstn),
    .rq0_tdata(rq0_tdata), .rq0_tkeep(rq0_tkeep), .rq0_tlast(rq0_tlast),
    .rq0_tuser(rq0_tuser), .rq0_tvalid(rq0_tvalid), .rq0_tready(rq0_tready),
    .rq1_tdata(rq1_tdata), .rq1_tkeep(rq1_tkeep), .rq1_tlast(rq1_tlast),
    .rq1_tuser(rq1_tuser), .rq1_tvalid(rq1_tvalid), .rq1_tready(rq1_tready),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast),
    .tx_tuser(tx_tuser), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .wdog_err(wdog_err)
  );

  pcie_tlp_tx_arb #(.CPL_PRIO(0), .MAX_BEATS(258)) u_rr (
    .pcie_clk(clk), .pcie_rstn(rstn),
    .rq0_tdata(64'hAAAA_0000_0000_0000), .rq0_tkeep(8'hFF), .rq0_tlast(1'b1),
    .rq0_tuser(4'h0), .rq0_tvalid(r0_tvalid), .rq0_tready(r0_tready),
    .rq1_tdata(64'hBBBB_0000_0000_0000), .rq1_tkeep(8'hFF), .rq1_tlast(1'b1),
    .rq1_tuser(4'h1), .rq1_tvalid(r1_tvalid), .rq1_tready(r1_tready),
    .tx_tdata(r_tx_tdata), .tx_tkeep(r_tx_tkeep), .tx_tlast(r_tx_tlast),
    .tx_tuser(r_tx_tuser), .tx_tvalid(r_tx_tvalid), .tx_tready(1'b1),
    .grant(r_grant), .pkt_cnt0(r_cnt0), .pkt_cnt1(r_cnt1), .wdog_err(r_wdog)
  );

  int checks = 0, failures = 0;

  task automatic chk(string tag, logic [79:0] got, logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(logic [63:0] d, logic [7:0] k, logic l, logic [3:0] u);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    return b;
  endfunction

  beat_t src0[$], src1[$], expq[$];
  logic  stall_mode = 1'b0;
  logic [3:0] pat = 4'b1001;
  int    cyc = 0;
  logic  hs0, hs1;

  // Source drivers and tx_tready pattern; queues advance on observed handshakes.
  initial begin
    rq0_tvalid = 0; rq1_tvalid = 0; tx_tready = 1;
    {rq0_tdata, rq0_tkeep, rq0_tlast, rq0_tuser} = '0;
    {rq1_tdata, rq1_tkeep, rq1_tlast, rq1_tuser} = '0;
    forever begin
      @(negedge clk);
      hs0 = rq0_tvalid && rq0_tready;
      hs1 = rq1_tvalid && rq1_tready;
      @(posedge clk); #1;
      cyc++;
      if (hs0 && src0.size() > 0) src0.delete(0);
      if (hs1 && src1.size() > 0) src1.delete(0);
      if (src0.size() > 0) begin {rq0_tdata, rq0_tkeep, rq0_tlast, rq0_tuser} = src0[0]; rq0_tvalid = 1; end
      else rq0_tvalid = 0;
      if (src1.size() > 0) begin {rq1_tdata, rq1_tkeep, rq1_tlast, rq1_tuser} = src1[0]; rq1_tvalid = 1; end
      else rq1_tvalid = 0;
      tx_tready = stall_mode ? pat[cyc % 4] : 1'b1;
    end
  end

  // Output monitor: scoreboard compare, stall stability, grant/ready consistency.
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (prev_stall) chk("tx_stable", 80'({tx_tdata, tx_tkeep, tx_tlast, tx_tuser}), 80'(prev_beat));
        if (tx_tvalid && tx_tready) begin
          if (expq.size() == 0) chk("tx_unexp", 80'(1), 80'(0));
          else begin
            e = expq.pop_front();
            chk("tx_beat", 80'({tx_tdata, tx_tkeep, tx_tlast, tx_tuser}), 80'(e));
          end
        end
        if (rq0_tready || rq1_tready)
          chk("tready_gnt", 80'({rq1_tready, rq0_tready}), 80'(grant));
        prev_stall = tx_tvalid && !tx_tready;
        prev_beat  = {tx_tdata, tx_tkeep, tx_tlast, tx_tuser};
      end else prev_stall = 1'b0;
    end
  end

  task automatic wait_hs(int which, int n, int limit, string tag);
    int c = 0, t = 0;
    while (c < n && t < limit) begin
      @(negedge clk);
      t++;
      if (which == 0 ? (rq0_tvalid && rq0_tready) : (rq1_tvalid && rq1_tready)) c++;
    end
    chk(tag, 80'(c), 80'(n));
  endtask

  task automatic drain(string tag, int limit);
    int t = 0;
    while ((expq.size() != 0 || src0.size() != 0 || src1.size() != 0) && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 80'(t >= limit), 80'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    beat_t b;
    logic  gexp, dexp;
    r0_tvalid = 0; r1_tvalid = 0;
    rstn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 80'(tx_tvalid), 80'(0));
    chk("rst_grant",  80'(grant), 80'(0));
    chk("rst_rdy",    80'({rq0_tready, rq1_tready}), 80'(0));
    chk("rst_cnt",    80'({pkt_cnt0, pkt_cnt1}), 80'(0));
    chk("rst_wdog",   80'(wdog_err), 80'(0));
    rstn = 1;

    // 2-beat MRd from rq0, 1-cycle latency to tx.
    @(negedge clk);
    b = mk(64'h0000_000F_0000_0001, 8'hFF, 1'b0, 4'h0); src0.push_back(b); expq.push_back(b);
    b = mk(64'h0000_0000_0000_1000, 8'h0F, 1'b1, 4'h0); src0.push_back(b); expq.push_back(b);
    wait_hs(0, 1, 20, "mrd_hs");
    chk("mrd_grant", 80'(grant), 80'(2'b01));
    @(negedge clk);
    chk("mrd_lat_v", 80'(tx_tvalid), 80'(1));
    chk("mrd_lat_d", 80'(tx_tdata), 80'(64'h0000_000F_0000_0001));
    drain("mrd_drain", 20);
    chk("mrd_cnt0", 80'(pkt_cnt0), 80'(1));

    // Both valid together: 3-beat CplD first, then rq0.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      b = mk(64'h4A00_0000_0000_0000 | 64'(i), 8'hFF, i == 2, 4'h1);
      src1.push_back(b); expq.push_back(b);
    end
    for (int i = 0; i < 2; i++) begin
      b = mk(64'h0100_0000_0000_0000 | 64'(i), 8'hFF, i == 1, 4'h2);
      src0.push_back(b);
    end
    for (int i = 0; i < 2; i++) expq.push_back(src0[i]);
    drain("prio_drain", 40);
    chk("prio_cnt1", 80'(pkt_cnt1), 80'(1));
    chk("prio_cnt0", 80'(pkt_cnt0), 80'(2));

    // 4-beat packet under tx_tready pattern 1,0,0,1.
    @(negedge clk);
    stall_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = mk(64'hD000_0000_0000_0000 | 64'(i * 17), 8'hFF, i == 3, 4'(i));
      src0.push_back(b); expq.push_back(b);
    end
    drain("stall_drain", 60);
    stall_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_cnt0", 80'(pkt_cnt0), 80'(3));

    // Runaway packet: 300 beats, no tlast; beat 258 must carry forced tlast.
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      b = mk({32'hA5A5_0000, 32'(i)}, 8'hFF, 1'b0, 4'(i));
      src0.push_back(b);
      b.l = (i == 257);
      expq.push_back(b);
    end
    wait_hs(0, 258, 400, "wd_hs");
    @(negedge clk);
    chk("wd_idle", 80'(grant), 80'(0));
    chk("wd_err",  80'(wdog_err), 80'(1));
    drain("wd_drain", 200);
    chk("wd_sticky", 80'(wdog_err), 80'(1));

    // Reset during beat 2 of 4, then a clean packet afterwards.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b = mk(64'hE000_0000_0000_0000 | 64'(i), 8'hFF, i == 3, 4'h3);
      src0.push_back(b); expq.push_back(b);
    end
    wait_hs(0, 2, 20, "rstm_hs");
    #1;
    rstn = 0;
    src0.delete(); expq.delete();
    @(negedge clk);
    chk("rstm_tvalid", 80'(tx_tvalid), 80'(0));
    chk("rstm_cnt",    80'({pkt_cnt0, pkt_cnt1}), 80'(0));
    chk("rstm_grant",  80'(grant), 80'(0));
    chk("rstm_wdog",   80'(wdog_err), 80'(0));
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("rstm_idle_tv", 80'(tx_tvalid), 80'(0));
    for (int i = 0; i < 2; i++) begin
      b = mk(64'hF000_0000_0000_0000 | 64'(i), 8'h3F, i == 1, 4'h4);
      src0.push_back(b); expq.push_back(b);
    end
    drain("rstm_drain", 20);
    chk("rstm_cnt0", 80'(pkt_cnt0), 80'(1));

    // Round-robin instance: serve rq0 once, then both continuously valid.
    @(negedge clk);
    r0_tvalid = 1;
    begin
      int t = 0;
      while (!(r0_tvalid && r0_tready) && t < 20) begin @(negedge clk); t++; end
      chk("rr_first", 80'(r0_tready), 80'(1));
    end
    @(posedge clk); #1;
    r0_tvalid = 0;
    repeat (3) @(negedge clk);
    r0_tvalid = 1; r1_tvalid = 1;
    gexp = 1'b1; dexp = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (r_grant != 2'b00) begin
        chk("rr_grant", 80'(r_grant), gexp ? 80'(2'b10) : 80'(2'b01));
        gexp = ~gexp;
      end
      if (r_tx_tvalid) begin
        chk("rr_data", 80'(r_tx_tdata), dexp ? 80'(64'hBBBB_0000_0000_0000) : 80'(64'hAAAA_0000_0000_0000));
        dexp = ~dexp;
      end
    end
    @(posedge clk); #1;
    r0_tvalid = 0; r1_tvalid = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
